// File: rtl/cordic_ln_vectoring.sv
// Iterative hyperbolic CORDIC in vectoring mode: RESULT = ln(A_IN) = 2*atanh((A-1)/(A+1)).
// state  | meaning
// IDLE   | waiting for START, operand captured on acceptance
// ITER   | one micro-rotation per cycle, STEPS cycles in total
// FINISH | DONE pulse, RESULT/ERR already latched
module cordic_ln_vectoring #(
  parameter int W     = 32,
  parameter int FRAC  = 24,
  parameter int ITER  = 24,
  parameter int GUARD = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A_IN,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic         ERR
);
  localparam int IW   = W + 2 * GUARD;
  localparam int IFR  = FRAC + GUARD;
  localparam int SW   = $clog2(ITER + 2);
  localparam int SMAX = (1 << SW) - 1;

  function automatic logic [SMAX:0] rep_mask_f();
    logic [SMAX:0] m;
    int r;
    m = '0;
    r = 4;
    while (r <= ITER) begin
      m[r[SW-1:0]] = 1'b1;
      r = 3 * r + 1;
    end
    return m;
  endfunction

  // atanh(2^-i) by its odd power series in 62-bit fixed point, rounded to IFR fraction bits
  function automatic logic [IW-1:0] atanh_const(input int i);
    logic [63:0] acc;
    int p;
    acc = '0;
    if (i >= 1 && i <= ITER) begin
      for (int k = 0; k < 32; k++) begin
        p = i * (2 * k + 1);
        if (p <= 62) acc = acc + ((64'd1 << (62 - p)) / 64'(2 * k + 1));
      end
      acc = (acc + (64'd1 << (61 - IFR))) >> (62 - IFR);
    end
    return acc[IW-1:0];
  endfunction

  localparam logic [SMAX:0] REP_MASK = rep_mask_f();
  localparam int STEPS = ITER + $countones(REP_MASK);
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic signed [IW-1:0] ONE   = {{(IW-IFR-1){1'b0}}, 1'b1, {IFR{1'b0}}};
  localparam logic signed [W-1:0]  A_LO  = W'(1) << (FRAC - 3);
  localparam logic signed [W-1:0]  A_HI  = W'(9) << FRAC;
  localparam logic signed [IW:0]   R_MAX = {{(IW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [IW:0]   R_MIN = ~R_MAX;
  localparam logic signed [IW:0]   RND   = (IW+1)'((1 << GUARD) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

  logic signed [IW-1:0] atanh_rom [0:SMAX];
  for (genvar g = 0; g <= SMAX; g++) begin : g_rom
    localparam logic [IW-1:0] ENTRY = atanh_const(g);
    assign atanh_rom[g] = ENTRY;
  end

  state_t               state_q, state_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic                 rep_q, rep_d;
  logic                 err_pend_q, err_pend_d;
  logic [W-1:0]         result_q, result_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic signed [IW-1:0] a_ext, x_sh, y_sh, ang;
  logic signed [IW:0]   z2, z_rnd;

  assign a_ext = {{GUARD{A_IN[W-1]}}, A_IN, {GUARD{1'b0}}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      cnt_q      <= '0;
      shift_q    <= SW'(1);
      rep_q      <= 1'b0;
      err_pend_q <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rep_q      <= rep_d;
      err_pend_q <= err_pend_d;
      result_q   <= result_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (START) state_d = S_ITER;
      S_ITER:   if (cnt_q == CW'(1)) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    err_pend_d = err_pend_q;
    result_d   = result_q;
    err_d      = err_q;
    done_d     = 1'b0;
    x_sh       = x_q >>> shift_q;
    y_sh       = y_q >>> shift_q;
    ang        = atanh_rom[shift_q];
    z2         = '0;
    z_rnd      = '0;
    if (state_q == S_IDLE && START) begin
      x_d        = a_ext + ONE;
      y_d        = a_ext - ONE;
      z_d        = '0;
      cnt_d      = CW'(STEPS);
      shift_d    = SW'(1);
      rep_d      = 1'b0;
      err_pend_d = ($signed(A_IN) < A_LO) || ($signed(A_IN) > A_HI);
    end else if (state_q == S_ITER) begin
      if (y_q[IW-1]) begin
        x_d = x_q + y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - ang;
      end else begin
        x_d = x_q - y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + ang;
      end
      cnt_d = cnt_q - CW'(1);
      // Repeated indices hold the shift for one extra pass
      if (REP_MASK[shift_q] && !rep_q) begin
        rep_d = 1'b1;
      end else begin
        rep_d   = 1'b0;
        shift_d = shift_q + SW'(1);
      end
      if (cnt_q == CW'(1)) begin
        done_d = 1'b1;
        z2     = {z_d, 1'b0};
        if (z2[IW]) z2 = z2 + RND;
        z_rnd  = z2 >>> GUARD;
        if (err_pend_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          err_d = 1'b0;
          if (z_rnd > R_MAX)      result_d = R_MAX[W-1:0];
          else if (z_rnd < R_MIN) result_d = R_MIN[W-1:0];
          else                    result_d = z_rnd[W-1:0];
        end
      end
    end
  end

  always_comb begin
    BUSY   = (state_q != S_IDLE);
    DONE   = done_q;
    RESULT = result_q;
    ERR    = err_q;
  end

endmodule
